pe_mac: RTL
===========

PE_MAC -- requirements
Module: pe_mac

Interface
REQ-001 Parameter DATA_W, default 8: width of operands a and b.
REQ-002 Parameter ACC_W, default 24: accumulator width; SHALL be at least 2*DATA_W.
REQ-003 Parameter OUT_W, default 8: result width; SHALL be at most ACC_W.
REQ-004 Parameter SHIFT, default 0: right-shift applied to the accumulator before output; SHALL be less than ACC_W.
REQ-005 Parameter SIGNED, default 0: 0 means unsigned arithmetic; 1 means two's-complement arithmetic and an arithmetic shift.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 in_valid  in  1  an operand beat is present.
REQ-009 in_ready  out  1  the block can accept a beat.
REQ-010 a  in  DATA_W  activation operand.
REQ-011 b  in  DATA_W  weight operand.
REQ-012 last  in  1  this beat closes the current accumulation group.
REQ-013 sat_en  in  1  1 selects saturation, 0 selects truncation; sampled only on a last beat.
REQ-014 out_valid  out  1  a result is held on out_data.
REQ-015 out_ready  in  1  the consumer accepts the result.
REQ-016 out_data  out  OUT_W  group result.
REQ-017 out_ovf  out  1  the accumulator overflowed ACC_W during the group; qualified by out_valid.

Function
REQ-018 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b, last and sat_en are captured on that edge.
REQ-019 Stage 1, at the accept edge: prod_r <= a*b at full 2*DATA_W width, signedness per SIGNED. p_v, p_last and p_sat SHALL be registered alongside prod_r.
REQ-020 Stage 2, at the edge after acceptance, when p_v is 1: sum = acc + prod_r, with prod_r sign- or zero-extended to ACC_W and the sum wrapping at ACC_W.
REQ-021 The first beat of a group SHALL add to an acc value of zero; no explicit clear input exists.
REQ-022 Overflow SHALL be detected on each stage-2 add: unsigned means a carry out of ACC_W; signed means operands of equal sign giving a result of opposite sign. A group-sticky ovf bit SHALL be set on any such overflow.
REQ-023 Stage-2 add when p_last is 0: acc <= sum; state remains ACCUM.
REQ-024 Stage-2 add when p_last is 1, all on the same edge:
  - out_data <= fmt(sum)
  - out_ovf <= ovf, including any overflow on this add
  - out_valid <= 1
  - acc <= 0, ovf <= 0
  - state <= HOLD
REQ-025 fmt(x): s = x >> SHIFT (arithmetic shift when SIGNED=1).
  - p_sat=1: clamp s to the OUT_W range, unsigned [0, 2^OUT_W-1] or signed [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - p_sat=0: s[OUT_W-1:0].
REQ-026 Latency: a last beat accepted at edge k SHALL produce out_valid=1 after edge k+1.
REQ-027 State machine, two states:
  - ACCUM -> HOLD on a stage-2 last add.
  - HOLD -> ACCUM on the edge where out_valid and out_ready are both 1; that edge also clears out_valid.
REQ-028 in_ready = (state==ACCUM) and not (p_v and p_last), combinational. No beat is accepted while a closing beat is in flight or a result is held.
REQ-029 In HOLD, out_data and out_ovf SHALL remain stable until the handshake.
REQ-030 The first cycle after a handshake SHALL have in_ready=1; there is no same-cycle bypass from output handshake to input acceptance.
REQ-031 Non-last beats SHALL stream at one beat per cycle with no bubbles.
REQ-032 A group of any length of 1 or more beats SHALL be supported; group length is unbounded except by accumulator wrap, which is flagged by out_ovf.

Reset
REQ-033 While rst is 1, at each edge:
  - acc, ovf, prod_r, p_v, p_last, p_sat <= 0
  - out_data <= 0, out_ovf <= 0, out_valid <= 0
  - state <= ACCUM
REQ-034 Reset SHALL take priority over every other event, including an accept or output handshake on the same edge.
REQ-035 A partial group or held result at reset SHALL be discarded without producing output.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (defaults unless stated)
REQ-037 Single beat a=3, b=5, last=1 -> out_valid=1 one edge later, out_data=15, out_ovf=0.
REQ-038 Four beats a=16, b=16, last on the 4th:
  - sat_en=1 -> out_data=255.
  - sat_en=0 -> out_data=0 (1024 truncated).
  - SHIFT=4, sat_en=0 -> out_data=64.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_data is stable and in_ready=0 throughout.
  - out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
  - The next group a=1, b=1, last -> 1.
REQ-040 rst=1 after 2 non-last beats of a=100, b=100, then a new single beat a=2, b=2, last -> out_data=4, with no residue.
REQ-041 SIGNED=1:
  - a=0xFD (-3), b=7, sat_en=0 -> out_data=0xEB (-21).
  - Two beats of a=0x80, b=1, sat_en=1 -> out_data=0x80 (clamped -128 from -256).
REQ-042 ACC_W=16, two beats a=255, b=255, last on the 2nd -> out_ovf=1. The following group a=1, b=1, last -> out_ovf=0.

Source files
------------

// File: rtl/pe_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_mac                                                          |
// | Brief    : Pipelined multiply-accumulate processing element with grouped   |
// |            accumulation, shift/saturate formatting and a held result.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pe_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              last,
    input  logic              sat_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int c_PROD_W = 2 * DATA_W;
    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_HOLD  = 1'b1;
    localparam logic [ACC_W-1:0] c_UMAX = (ACC_W'(1) << OUT_W) - ACC_W'(1);
    localparam logic [ACC_W-1:0] c_SMAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic [ACC_W-1:0] c_SMIN = ~c_SMAX;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_PROD_W-1:0] r_prod;
    logic                r_p_v;
    logic                r_p_last;
    logic                r_p_sat;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;
    logic [OUT_W-1:0]    r_out_data;
    logic                r_out_ovf;
    logic                r_out_valid;

    logic                w_accept;
    logic [c_PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W:0]      w_sum_full;
    logic [ACC_W-1:0]    w_sum;
    logic                w_ovf_add;
    logic [ACC_W-1:0]    w_shift;
    logic [OUT_W-1:0]    w_fmt;

    assign w_accept   = in_valid && in_ready;
    assign w_sum_full = {1'b0, r_acc} + {1'b0, w_prod_ext};
    assign w_sum      = w_sum_full[ACC_W-1:0];

    // Arithmetic datapath; SIGNED picks sign handling for product, extension, overflow and shift.
    always_comb begin
        w_prod     = c_PROD_W'(a) * c_PROD_W'(b);
        w_prod_ext = ACC_W'(r_prod);
        w_ovf_add  = w_sum_full[ACC_W];
        w_shift    = w_sum >> SHIFT;
        if (SIGNED != 0) begin
            w_prod     = c_PROD_W'($signed(a)) * c_PROD_W'($signed(b));
            w_prod_ext = ACC_W'($signed(r_prod));
            w_ovf_add  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                         (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
            w_shift    = ACC_W'($signed(w_sum) >>> SHIFT);
        end
    end

    always_comb begin
        w_fmt = w_shift[OUT_W-1:0];
        if (r_p_sat) begin
            if (SIGNED != 0) begin
                if ($signed(w_shift) > $signed(c_SMAX)) begin
                    w_fmt = c_SMAX[OUT_W-1:0];
                end else if ($signed(w_shift) < $signed(c_SMIN)) begin
                    w_fmt = c_SMIN[OUT_W-1:0];
                end
            end else if (w_shift > c_UMAX) begin
                w_fmt = c_UMAX[OUT_W-1:0];
            end
        end
    end

    // No beat is taken while a closing beat is in flight or a result is held.
    always_comb begin
        w_state_next = r_state;
        in_ready     = (r_state == c_ST_ACCUM) && !(r_p_v && r_p_last);
        case (r_state)
            c_ST_ACCUM: if (r_p_v && r_p_last) w_state_next = c_ST_HOLD;
            c_ST_HOLD:  if (r_out_valid && out_ready) w_state_next = c_ST_ACCUM;
            default:    w_state_next = c_ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_ACCUM;
            r_prod      <= '0;
            r_p_v       <= 1'b0;
            r_p_last    <= 1'b0;
            r_p_sat     <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_p_v   <= w_accept;
            if (w_accept) begin
                r_prod   <= w_prod;
                r_p_last <= last;
                r_p_sat  <= sat_en;
            end
            if (r_state == c_ST_HOLD && r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_p_v) begin
                if (r_p_last) begin
                    r_out_data  <= w_fmt;
                    r_out_ovf   <= r_ovf | w_ovf_add;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_sum;
                    r_ovf <= r_ovf | w_ovf_add;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
